// File: rtl/result_serializer_if.sv
// Valid/ready word stream carrying serialized result words to the downstream consumer.
interface result_serializer_if #(
   parameter int BIT_WIDTH = 16
);
   logic [BIT_WIDTH-1:0] o_data;
   logic                 o_valid;
   logic                 o_last;
   logic                 i_ready;

   modport master (output o_data, output o_valid, output o_last, input i_ready);
   modport slave  (input o_data, input o_valid, input o_last, output i_ready);
endinterface

// File: rtl/result_serializer.sv
// Snapshots a parallel result frame and streams it one word per cycle over valid/ready.
// Optional SER_HEADER_EN: emit a {mode, N_WORDS} header word ahead of the frame data.
module result_serializer #(
   parameter int BIT_WIDTH = 16,
   parameter int N_WORDS   = 64
) (
   input  logic                 i_clk,
   input  logic                 i_rstb,
   input  logic [BIT_WIDTH-1:0] i_frame [N_WORDS-1:0],
   input  logic                 i_start,
   input  logic [1:0]           i_mode,
   result_serializer_if.master  m_if,
   output logic                 o_busy,
   output logic                 o_done
);
   localparam int IDX_W = $clog2(N_WORDS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);

   typedef enum logic [1:0] {S_IDLE, S_HEADER, S_STREAM, S_DONE} state_t;

   state_t               state_q, state_d;
   logic [IDX_W-1:0]     idx_q, idx_d, idx_inc;
   logic [BIT_WIDTH-1:0] buf_q [N_WORDS-1:0];
   logic [BIT_WIDTH-1:0] buf_d [N_WORDS-1:0];
   logic [BIT_WIDTH-1:0] data_q, data_d;
   logic                 valid_q, valid_d;
   logic                 last_q, last_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 capture;
   logic                 xfer;

   assign capture = (state_q == S_IDLE) && i_start && (i_mode != 2'b00);
   assign xfer    = valid_q && m_if.i_ready;
   assign idx_inc = idx_q + 1'b1;

   always_comb begin
      buf_d = buf_q;
      if (capture) begin
         buf_d = i_frame;
      end
   end

   // Output word is registered, so the next word is looked up one edge ahead.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      data_d  = data_q;
      valid_d = valid_q;
      last_d  = last_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (capture) begin
               busy_d  = 1'b1;
               valid_d = 1'b1;
               last_d  = 1'b0;
               idx_d   = '0;
`ifdef SER_HEADER_EN
               state_d = S_HEADER;
               data_d  = {i_mode, (BIT_WIDTH-2)'(N_WORDS)};
`else
               state_d = S_STREAM;
               data_d  = i_frame[0];
`endif
            end
         end
         S_HEADER: begin
            if (xfer) begin
               state_d = S_STREAM;
               data_d  = buf_q[0];
               last_d  = 1'b0;
            end
         end
         S_STREAM: begin
            if (xfer) begin
               if (idx_q == LAST_IDX) begin
                  state_d = S_DONE;
                  idx_d   = '0;
                  data_d  = '0;
                  valid_d = 1'b0;
                  last_d  = 1'b0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  idx_d  = idx_inc;
                  data_d = buf_q[idx_inc];
                  last_d = (idx_inc == LAST_IDX);
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      buf_q <= buf_d;
   end

   always_ff @(posedge i_clk) begin
      if (i_rstb) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         last_q  <= last_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign m_if.o_data  = data_q;
   assign m_if.o_valid = valid_q;
   assign m_if.o_last  = last_q;
   assign o_busy       = busy_q;
   assign o_done       = done_q;
endmodule

// File: tb/tb_result_serializer.sv
// Self-checking bench: a queue of expected transfers is built from each accepted frame
// and every cycle's outputs are compared against the head of that queue.
module tb_result_serializer;
   localparam int BW = 16;
   localparam int N  = 64;
`ifdef SER_HEADER_EN
   localparam int HDR = 1;
`else
   localparam int HDR = 0;
`endif
   localparam int NX = N + HDR;

   logic          clk = 1'b0;
   logic          rstb = 1'b1;
   logic [BW-1:0] frame [N-1:0];
   logic          start = 1'b0;
   logic [1:0]    mode = 2'b00;
   logic          busy;
   logic          done;

   always #5 clk = ~clk;

   result_serializer_if #(.BIT_WIDTH(BW)) s_if ();

   result_serializer #(.BIT_WIDTH(BW), .N_WORDS(N)) dut (
      .i_clk   (clk),
      .i_rstb  (rstb),
      .i_frame (frame),
      .i_start (start),
      .i_mode  (mode),
      .m_if    (s_if),
      .o_busy  (busy),
      .o_done  (done)
   );

   typedef struct {
      logic [BW-1:0] data;
      logic          last;
   } exp_t;

   typedef struct {
      logic [1:0] mode;
      int         rdy_kind;   // 0 always ready, 1 toggle 1,0,1,0, 2 random
      int         data_kind;  // 0 ramp 3k, 1 random
      int         exp_xfers;
      int         exp_cycles; // valid cycles for the frame, -1 = not checked
   } vec_t;

   exp_t exp_q[$];
   int   tests = 0;
   int   fails = 0;
   int   n_xfer, n_valid, n_done;
   bit   done_due = 0;

   task automatic chk(input string name, input longint act, input longint req);
      tests++;
      if (act != req) begin
         fails++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic push_frame();
      exp_t e;
      if (HDR != 0) begin
         e.data = BW'((int'(mode) << (BW - 2)) | N);
         e.last = 1'b0;
         exp_q.push_back(e);
      end
      for (int k = 0; k < N; k++) begin
         e.data = frame[k];
         e.last = (k == N - 1);
         exp_q.push_back(e);
      end
   endtask

   // Compare outputs against the reference, then advance the reference by one edge.
   task automatic monitor();
      bit   idle;
      exp_t e;
      idle = (exp_q.size() == 0) && !done_due;
      chk("o_valid", s_if.o_valid, exp_q.size() != 0);
      chk("o_busy", busy, exp_q.size() != 0);
      chk("o_done", done, done_due);
      if (done) n_done++;
      if (s_if.o_valid) n_valid++;
      if (s_if.o_valid && s_if.i_ready) n_xfer++;
      done_due = 0;
      if (exp_q.size() != 0) begin
         e = exp_q[0];
         chk("o_data", s_if.o_data, e.data);
         chk("o_last", s_if.o_last, e.last);
         if (s_if.i_ready) begin
            void'(exp_q.pop_front());
            if (exp_q.size() == 0) done_due = 1;
         end
      end
      if (rstb) begin
         exp_q.delete();
         done_due = 0;
      end else if (start && (mode != 2'b00) && idle) begin
         push_frame();
      end
   endtask

   task automatic step();
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ready(input int kind);
      case (kind)
         0:       s_if.i_ready = 1'b1;
         1:       s_if.i_ready = (n_valid % 2 == 0);
         default: s_if.i_ready = 1'($urandom_range(0, 1));
      endcase
   endtask

   task automatic run_frame(input vec_t v);
      int cyc;
      n_xfer = 0; n_valid = 0; n_done = 0;
      for (int k = 0; k < N; k++) frame[k] = (v.data_kind == 0) ? BW'(3 * k) : BW'($urandom);
      mode = v.mode;
      start = 1'b1;
      s_if.i_ready = 1'b1;
      step();
      start = 1'b0;
      cyc = 0;
      while ((exp_q.size() != 0 || done_due) && cyc < 2000) begin
         set_ready(v.rdy_kind);
         step();
         cyc++;
      end
      if (cyc >= 2000) chk("frame_timeout", cyc, 0);
      s_if.i_ready = 1'b1;
      step();
      step();
      chk("xfer_count", n_xfer, v.exp_xfers);
      if (v.exp_cycles >= 0) chk("valid_cycles", n_valid, v.exp_cycles);
      chk("done_pulses", n_done, (v.mode != 2'b00) ? 1 : 0);
   endtask

   initial begin
      vec_t vecs [6];
      vec_t rv;
      int   cyc;

      vecs[0] = '{mode: 2'b01, rdy_kind: 0, data_kind: 0, exp_xfers: NX, exp_cycles: NX};
      vecs[1] = '{mode: 2'b01, rdy_kind: 1, data_kind: 0, exp_xfers: NX, exp_cycles: 2 * NX - 1};
      vecs[2] = '{mode: 2'b00, rdy_kind: 0, data_kind: 1, exp_xfers: 0,  exp_cycles: 0};
      vecs[3] = '{mode: 2'b10, rdy_kind: 0, data_kind: 1, exp_xfers: NX, exp_cycles: NX};
      vecs[4] = '{mode: 2'b11, rdy_kind: 1, data_kind: 1, exp_xfers: NX, exp_cycles: 2 * NX - 1};
      vecs[5] = '{mode: 2'b00, rdy_kind: 1, data_kind: 0, exp_xfers: 0,  exp_cycles: 0};

      for (int k = 0; k < N; k++) frame[k] = '0;
      s_if.i_ready = 1'b1;

      // Reset state
      @(posedge clk); #1;
      step();
      step();
      rstb = 1'b0;
      chk("reset_o_data", s_if.o_data, 0);
      chk("reset_o_last", s_if.o_last, 0);
      chk("reset_o_valid", s_if.o_valid, 0);
      step();

      for (int i = 0; i < 6; i++) begin
         $display("[TB] vector %0d: mode=%0d ready_kind=%0d", i, vecs[i].mode, vecs[i].rdy_kind);
         run_frame(vecs[i]);
      end

      // Snapshot: overwrite frame and re-start mid-stream, then start during the done cycle
      $display("[TB] snapshot / ignored start sequence");
      n_xfer = 0; n_done = 0;
      for (int k = 0; k < N; k++) frame[k] = BW'(3 * k);
      mode = 2'b01; start = 1'b1; s_if.i_ready = 1'b1;
      step();
      start = 1'b0;
      for (int k = 0; k < N; k++) frame[k] = 16'hFFFF;
      cyc = 0;
      while (n_xfer < 10 + HDR && cyc < 500) begin step(); cyc++; end
      mode = 2'b10; start = 1'b1;
      step();
      start = 1'b0; mode = 2'b01;
      cyc = 0;
      while (!(exp_q.size() == 0 && done_due) && cyc < 500) begin step(); cyc++; end
      if (cyc >= 500) chk("snapshot_timeout", cyc, 0);
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      chk("snapshot_xfers", n_xfer, NX);
      chk("snapshot_done_pulses", n_done, 1);

      // Reset while word 20 is transferring, then a fresh frame restarts at word 0
      $display("[TB] reset mid-stream sequence");
      n_xfer = 0;
      for (int k = 0; k < N; k++) frame[k] = BW'($urandom);
      mode = 2'b11; start = 1'b1; s_if.i_ready = 1'b1;
      step();
      start = 1'b0;
      cyc = 0;
      while (n_xfer < 20 + HDR && cyc < 500) begin step(); cyc++; end
      rstb = 1'b1;
      step();
      rstb = 1'b0;
      chk("midreset_o_valid", s_if.o_valid, 0);
      chk("midreset_o_busy", busy, 0);
      chk("midreset_o_data", s_if.o_data, 0);
      step();
      rv = '{mode: 2'b10, rdy_kind: 0, data_kind: 1, exp_xfers: NX, exp_cycles: NX};
      run_frame(rv);

      // Randomized frames with random backpressure
      for (int i = 0; i < 6; i++) begin
         rv = '{mode: 2'($urandom_range(1, 3)), rdy_kind: 2, data_kind: 1, exp_xfers: NX, exp_cycles: -1};
         $display("[TB] random frame %0d: mode=%0d", i, rv.mode);
         run_frame(rv);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/result_serializer.md
Name: result_serializer

Overview:
- Output stage directly downstream of the top-level FFT/IFFT/FIR controller.
- The controller presents a finished 64-word result frame in parallel and pulses a start bit. This block snapshots the frame and streams it out one word per cycle over a valid/ready handshake.
- It frees the controller to accept the next input frame while the previous result drains.

Parameters:
- BIT_WIDTH, 16, width of each sample word and of the output word
- N_WORDS, 64, words per frame; power of two, minimum 4

Ports:
- i_clk  input  1  system clock; all logic on rising edge
- i_rstb  input  1  reset, synchronous, active-high
- i_frame  input  BIT_WIDTH x N_WORDS (unpacked [N_WORDS-1:0])  parallel result frame from controller
- i_start  input  1  frame-ready pulse from controller (o_start_bit)
- i_mode  input  2  mode of the frame: 01 FFT, 10 IFFT, 11 FIR, 00 idle
- i_ready  input  1  downstream consumer can accept a word this cycle
- o_data  output  BIT_WIDTH  serialized word
- o_valid  output  1  o_data holds a valid word
- o_last  output  1  high with the final word of the frame
- o_busy  output  1  frame captured and not yet fully sent
- o_done  output  1  one-cycle pulse after the final transfer

Behaviour:
- Reset (i_rstb=1 at an edge): state S_IDLE, word index 0, o_data=0, o_valid=0, o_last=0, o_busy=0, o_done=0. Reset takes priority over every other input, including mid-stream; the partial frame is discarded.
- States: S_IDLE, S_HEADER, S_STREAM, S_DONE.
- S_IDLE:
  - i_start=1 with i_mode!=00: capture all N_WORDS of i_frame and i_mode into internal registers, set o_busy=1.
  - Next state is S_HEADER (only with SER_HEADER_EN) or S_STREAM.
  - i_start with i_mode=00 is ignored.
- Latency: o_valid rises on the cycle after the capturing edge.
- Snapshot: after capture, changes on i_frame/i_mode have no effect on the current frame.
- S_STREAM:
  - o_data = buffer[index], starting at index 0.
  - A transfer occurs at an edge where o_valid && i_ready; index then increments.
  - o_valid && !i_ready: o_data, o_last and index hold stable. No drop, no duplicate.
  - i_ready held high gives one word per cycle with no bubbles.
- o_last=1 exactly while index==N_WORDS-1 and o_valid=1.
- Final word:
  - The edge transferring index N_WORDS-1 moves to S_DONE.
  - o_valid, o_last and o_busy drop to 0 on that edge; the index counter wraps to 0.
- S_DONE: o_done=1 for exactly one cycle, then S_IDLE. i_start during S_DONE is ignored; the earliest new capture is the following cycle.
- i_start while o_busy=1 (any non-idle state) is ignored. No queueing, no error flag.
- Index counter is $clog2(N_WORDS) bits wide; no arithmetic is performed on data words.
- o_busy is 1 in S_HEADER and S_STREAM, 0 otherwise.

Optional Feature:
- Macro: SER_HEADER_EN
- Defined:
  - After capture, enter S_HEADER and emit one header word before the data: o_data = {mode[1:0], (BIT_WIDTH-2)'(N_WORDS)}, o_valid=1, o_last=0.
  - The header uses the same handshake and holds under backpressure.
  - Its transfer moves to S_STREAM at index 0.
  - A frame is N_WORDS+1 transfers.
- Undefined: S_HEADER is absent and the frame is N_WORDS transfers.

Test Plan:
1. Reset, i_frame[k]=3k, i_mode=01, pulse i_start, i_ready=1 -> o_valid from the next cycle; 64 consecutive words 0,3,...,189; o_last only on 189; o_done one cycle after; o_busy then 0.
2. Same frame, i_ready toggling 1,0,1,0 -> each word held stable while i_ready=0; output sequence exactly 0..189 step 3; 64 transfers over 127 cycles.
3. After capture, overwrite i_frame with 16'hFFFF and pulse i_start with mode 10 at word 10 -> output still the original frame, single o_done. A start pulse during S_DONE also has no effect.
4. Assert i_rstb while transferring word 20 -> next cycle o_valid=0, o_busy=0, o_data=0. New i_start -> stream restarts at word 0 of the new frame.
5. i_start with i_mode=00 -> no capture; o_valid and o_busy stay 0.
6. SER_HEADER_EN defined, i_mode=01, BIT_WIDTH=16 -> first word 16'h4040 with o_last=0, then 64 data words, 65 transfers total. Undefined -> 64 transfers, first word is data word 0.
